// File: rtl/prog_interval_timer_pkg.sv
// Shared encodings for the programmable interval timer.
//   MODE_*  : run modes sampled on start
//   ST_*    : controller states
//   decode_mode : maps the raw mode input onto a legal run mode
package prog_interval_timer_pkg;

  localparam int unsigned MODE_W  = 2;
  localparam int unsigned STATE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_ONESHOT  = 2'b00,
    MODE_PERIODIC = 2'b01,
    MODE_UP       = 2'b10
  } mode_e;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10,
    ST_DONE   = 2'b11
  } state_e;

  // Encoding 11 is reserved and behaves as one-shot.
  function automatic mode_e decode_mode(input logic [MODE_W-1:0] raw);
    case (raw)
      2'b01:   return MODE_PERIODIC;
      2'b10:   return MODE_UP;
      default: return MODE_ONESHOT;
    endcase
  endfunction

endpackage

// File: rtl/prog_interval_timer_prescaler.sv
// Tick prescaler: emits tick once every prescale+1 enabled cycles.
//   clk, rst_n : clock, async active-low reset
//   clear      : restart the divider from zero (wins over enable)
//   enable     : advance the divider this cycle
//   prescale   : divisor minus one
//   tick       : combinational, high on the enabled cycle the divider wraps
module timer_prescaler #(
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt_q;

  // >= so that lowering prescale mid-run ticks at once instead of wrapping around.
  assign tick = enable && (cnt_q >= prescale);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= tick ? '0 : cnt_q + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/prog_interval_timer.sv
// Prescaled multi-mode interval timer (one-shot down, periodic down, free-run up).
//   clk, rst_n : clock, async active-low reset
//   load_en    : load data into count and reload; aborts any run
//   data       : load value
//   start      : arm from IDLE or re-arm from DONE; samples mode
//   pause      : level, freezes the timer while high
//   mode       : 00 one-shot, 01 periodic, 10 free-run up, 11 as 00
//   prescale   : tick every prescale+1 cycles
//   count      : current count (registered)
//   tc         : one-cycle terminal-count pulse (registered)
//   busy       : decoded from state, high in RUN or PAUSED
//   done       : sticky one-shot completion flag (registered)
module prog_interval_timer
  import prog_interval_timer_pkg::*;
#(
  parameter int unsigned WIDTH      = 9,
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_en,
  input  logic [WIDTH-1:0]      data,
  input  logic                  start,
  input  logic                  pause,
  input  logic [1:0]            mode,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  busy,
  output logic                  done
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [WIDTH-1:0] count_d;
  logic             tc_d, done_d;
  logic             arm;
  logic             tick;
  logic             ps_clear;
  logic             ps_enable;

  assign busy = (state_q == ST_RUN) || (state_q == ST_PAUSED);
  assign arm  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // A PAUSED timer whose pause has dropped counts on the resume edge, so a
  // pause of N cycles stretches the interval by exactly N cycles.
  assign ps_enable = busy && !pause && !load_en;
  assign ps_clear  = load_en || arm;

  timer_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (ps_clear),
    .enable  (ps_enable),
    .prescale(prescale),
    .tick    (tick)
  );

  // Next-state and next-output logic; priority load_en > start > pause > tick.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    reload_d = reload_q;
    count_d  = count;
    done_d   = done;
    tc_d     = 1'b0;

    if (load_en) begin
      count_d  = data;
      reload_d = data;
      state_d  = ST_IDLE;
      done_d   = 1'b0;
    end else if (arm) begin
      mode_d  = decode_mode(mode);
      state_d = ST_RUN;
      done_d  = 1'b0;
      if (state_q == ST_DONE) begin
        count_d = reload_q;
      end
    end else if (busy) begin
      if (pause) begin
        state_d = ST_PAUSED;
      end else begin
        state_d = ST_RUN;
        if (tick) begin
          if (mode_q == MODE_UP) begin
            count_d = count + WIDTH'(1);
            tc_d    = (count == '1);
          end else if (count != '0) begin
            count_d = count - WIDTH'(1);
          end else begin
            tc_d = 1'b1;
            if (mode_q == MODE_PERIODIC) begin
              count_d = reload_q;
            end else begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_ONESHOT;
      reload_q <= '0;
      count    <= '0;
      tc       <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      reload_q <= reload_d;
      count    <= count_d;
      tc       <= tc_d;
      done     <= done_d;
    end
  end

endmodule
